pulse_emitter: RTL and testbench

- Transmit-side counterpart to the pulse tracer (debounce/edge-detect receiver).
- Turns single-cycle trigger requests into clean, glitch-free pulses on one output line.
- Each pulse has a programmable high width, followed by a guaranteed low gap, so the receiver sees every pulse as one edge.
- Requests that arrive while a pulse is in flight are counted and replayed in order. Used as a stimulus source and as the on-chip driver of the traced line.

---
 rtl/pulse_emitter_pkg.sv | 25 ++
 rtl/pulse_req_counter.sv | 49 ++++
 rtl/pulse_emitter.sv | 180 ++++++++++++++++++
 tb/tb_pulse_emitter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_emitter_pkg.sv
// -----------------------------------------------------------------------------
// pulse_emitter_pkg
// Shared definitions for the pulse emitter: FSM state encoding, default
// widths and a helper that maps a programmed width of 0 onto 1.
// -----------------------------------------------------------------------------
package pulse_emitter_pkg;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_PEND_W = 4;

    // PRE_H / PRE_L are only reachable when PULSE_EMITTER_GLITCH_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIGH  = 3'd1,
        GAP   = 3'd2,
        PRE_H = 3'd3,
        PRE_L = 3'd4
    } state_t;

    // A programmed width of zero still yields one cycle.
    function automatic int unsigned clamp_min1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

endpackage

// File: rtl/pulse_req_counter.sv
// -----------------------------------------------------------------------------
// pulse_req_counter
// Saturating up/down counter holding the number of queued pulse requests.
// An increment without a decrement while full is discarded and flagged.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_inc      add one request
//   i_dec      remove one request (oldest request started)
//   o_count    current number of queued requests
//   o_full     count is at its maximum (2^PEND_W-1)
//   o_drop     one-cycle strobe, same cycle as the lost request
// -----------------------------------------------------------------------------
module pulse_req_counter #(
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_count,
    output logic              o_full,
    output logic              o_drop
);

    logic [PEND_W-1:0] r_count;
    logic              w_full;
    logic              w_up;
    logic              w_down;

    assign w_full = &r_count;
    // inc+dec together leaves the count unchanged, even when full.
    assign w_up   = i_inc & ~i_dec & ~w_full;
    assign w_down = i_dec & ~i_inc & (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (w_up)
            r_count <= r_count + PEND_W'(1);
        else if (w_down)
            r_count <= r_count - PEND_W'(1);
    end

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_drop  = i_inc & ~i_dec & w_full & ~rst;

endmodule

// File: rtl/pulse_emitter.sv
// -----------------------------------------------------------------------------
// pulse_emitter
// Turns single-cycle trigger requests into clean pulses: a programmable high
// width followed by a guaranteed low gap. Requests arriving while a pulse is
// in flight are counted and replayed back to back.
//
// Optional feature macro: PULSE_EMITTER_GLITCH_EN
//   Adds input glitch_req (sticky until used). The next started pulse is
//   preceded by a 1-cycle high (PRE_H) and a 1-cycle low (PRE_L).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   trig          one request per cycle high
//   high_cycles   pulse high width (0 treated as 1), sampled at pulse start
//   low_cycles    minimum low gap (0 treated as 1), sampled at pulse start
//   glitch_req    (macro only) request a glitch prefix on the next pulse
//   pulse_out     registered pulse line
//   busy          registered, high outside IDLE
//   done          one-cycle strobe in the first GAP cycle
//   pending       queued, not-yet-started requests
//   drop          one-cycle strobe when a request is lost to a full queue
// -----------------------------------------------------------------------------
module pulse_emitter
    import pulse_emitter_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [CNT_W-1:0]  high_cycles,
    input  logic [CNT_W-1:0]  low_cycles,
`ifdef PULSE_EMITTER_GLITCH_EN
    input  logic              glitch_req,
`endif
    output logic              pulse_out,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic              drop
);

    state_t            r_state;
    state_t            w_next;
    state_t            w_start_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  r_lo_m1;
    logic [CNT_W-1:0]  w_hi_m1;
    logic [CNT_W-1:0]  w_lo_m1;
    logic              w_cnt_zero;
    logic              w_have_pend;
    logic              w_start;
    logic              w_inc;
    logic              w_dec;
    logic              w_full;
    logic              w_pulse_d;
    logic              w_busy_d;
    logic              w_done_d;
    logic              r_pulse;
    logic              r_busy;
    logic              r_done;
    logic [PEND_W-1:0] w_pend;

    assign w_hi_m1    = CNT_W'(clamp_min1(32'(high_cycles)) - 1);
    assign w_lo_m1    = CNT_W'(clamp_min1(32'(low_cycles)) - 1);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_have_pend = (w_pend != '0);

    // A new pulse may start from IDLE or in the final GAP cycle; queued
    // requests take priority over a same-cycle trigger.
    assign w_start = ((r_state == IDLE) || (r_state == GAP && w_cnt_zero)) &&
                     (w_have_pend || trig);
    assign w_inc   = trig & ~(w_start & ~w_have_pend);
    assign w_dec   = w_start & w_have_pend;

`ifdef PULSE_EMITTER_GLITCH_EN
    logic r_glitch;

    always_ff @(posedge clk) begin
        if (rst)
            r_glitch <= 1'b0;
        else
            r_glitch <= (r_glitch & ~w_start) | glitch_req;
    end

    assign w_start_state = r_glitch ? PRE_H : HIGH;
`else
    assign w_start_state = HIGH;
`endif

    pulse_req_counter #(.PEND_W(PEND_W)) u_req_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_count (w_pend),
        .o_full  (w_full),
        .o_drop  (drop)
    );

    // State register, duration counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lo_m1 <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_start)
                r_lo_m1 <= w_lo_m1;
            r_pulse <= w_pulse_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    // Next-state and duration counter.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next    = w_start_state;
                    w_cnt_nxt = w_hi_m1;
                end
            end
            HIGH: begin
                if (w_cnt_zero) begin
                    w_next    = GAP;
                    w_cnt_nxt = r_lo_m1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_start) begin
                    w_next    = w_start_state;
                    w_cnt_nxt = w_hi_m1;
                end else begin
                    w_next    = IDLE;
                end
            end
`ifdef PULSE_EMITTER_GLITCH_EN
            // Counter holds the loaded high width through the prefix.
            PRE_H: w_next = PRE_L;
            PRE_L: w_next = HIGH;
`endif
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and then registered, so the
    // pulse line never carries decode glitches.
    always_comb begin
        w_pulse_d = (w_next == HIGH) || (w_next == PRE_H);
        w_busy_d  = (w_next != IDLE);
        w_done_d  = (r_state == HIGH) && (w_next == GAP);
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pending   = w_pend;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_pulse_emitter.sv
module tb_pulse_emitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic [7:0] hi = 8'd0;
    logic [7:0] lo = 8'd0;
    logic       pulse, busy, done, drop;
    logic [3:0] pend;

    logic       trig2 = 1'b0;
    logic [7:0] hi2 = 8'd5;
    logic [7:0] lo2 = 8'd1;
    logic       pulse2, busy2, done2, drop2;
    logic [1:0] pend2;

    logic       glitch_req = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_emitter #(.CNT_W(8), .PEND_W(4)) dut (
        .clk(clk), .rst(rst), .trig(trig), .high_cycles(hi), .low_cycles(lo),
`ifdef PULSE_EMITTER_GLITCH_EN
        .glitch_req(glitch_req),
`endif
        .pulse_out(pulse), .busy(busy), .done(done), .pending(pend), .drop(drop)
    );

    pulse_emitter #(.CNT_W(8), .PEND_W(2)) dut2 (
        .clk(clk), .rst(rst), .trig(trig2), .high_cycles(hi2), .low_cycles(lo2),
`ifdef PULSE_EMITTER_GLITCH_EN
        .glitch_req(1'b0),
`endif
        .pulse_out(pulse2), .busy(busy2), .done(done2), .pending(pend2), .drop(drop2)
    );

    typedef struct {
        logic       t;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] e;   // {pulse, busy, done, pending[3:0], drop}
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit t, int h, int l, bit p, bit b, bit d, int pn, bit dr);
        vec_t v;
        v.t = t;
        v.h = 8'(h);
        v.l = 8'(l);
        v.e = {p, b, d, 4'(pn), dr};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, mx, np;
        logic prev;
        logic [5:0] gpat;
        logic [3:0] cpat;

        // Single pulse H=3 L=2
        vq.push_back(mk(1,3,2, 0,0,0,0,0));
        vq.push_back(mk(0,3,2, 1,1,0,0,0));
        vq.push_back(mk(0,3,2, 1,1,0,0,0));
        vq.push_back(mk(0,3,2, 1,1,0,0,0));
        vq.push_back(mk(0,3,2, 0,1,1,0,0));
        vq.push_back(mk(0,3,2, 0,1,0,0,0));
        vq.push_back(mk(0,3,2, 0,0,0,0,0));
        // Queue: three triggers, H=2 L=2
        vq.push_back(mk(1,2,2, 0,0,0,0,0));
        vq.push_back(mk(1,2,2, 1,1,0,0,0));
        vq.push_back(mk(1,2,2, 1,1,0,1,0));
        vq.push_back(mk(0,2,2, 0,1,1,2,0));
        vq.push_back(mk(0,2,2, 0,1,0,2,0));
        vq.push_back(mk(0,2,2, 1,1,0,1,0));
        vq.push_back(mk(0,2,2, 1,1,0,1,0));
        vq.push_back(mk(0,2,2, 0,1,1,1,0));
        vq.push_back(mk(0,2,2, 0,1,0,1,0));
        vq.push_back(mk(0,2,2, 1,1,0,0,0));
        vq.push_back(mk(0,2,2, 1,1,0,0,0));
        vq.push_back(mk(0,2,2, 0,1,1,0,0));
        vq.push_back(mk(0,2,2, 0,1,0,0,0));
        vq.push_back(mk(0,2,2, 0,0,0,0,0));
        // Zero widths, back-to-back via queue
        vq.push_back(mk(1,0,0, 0,0,0,0,0));
        vq.push_back(mk(1,0,0, 1,1,0,0,0));
        vq.push_back(mk(0,0,0, 0,1,1,1,0));
        vq.push_back(mk(0,0,0, 1,1,0,0,0));
        vq.push_back(mk(0,0,0, 0,1,1,0,0));
        vq.push_back(mk(0,0,0, 0,0,0,0,0));
        // Width change mid-pulse is ignored
        vq.push_back(mk(1,3,1, 0,0,0,0,0));
        vq.push_back(mk(0,7,1, 1,1,0,0,0));
        vq.push_back(mk(0,7,1, 1,1,0,0,0));
        vq.push_back(mk(0,7,1, 1,1,0,0,0));
        vq.push_back(mk(0,7,1, 0,1,1,0,0));
        vq.push_back(mk(0,7,1, 0,0,0,0,0));
        // Trigger in last GAP cycle with empty queue is consumed directly
        vq.push_back(mk(1,1,1, 0,0,0,0,0));
        vq.push_back(mk(0,1,1, 1,1,0,0,0));
        vq.push_back(mk(1,1,1, 0,1,1,0,0));
        vq.push_back(mk(0,1,1, 1,1,0,0,0));
        vq.push_back(mk(0,1,1, 0,1,1,0,0));
        vq.push_back(mk(0,1,1, 0,0,0,0,0));

        // Reset held two edges with trig high
        rst = 1'b1; trig = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_c1", {pulse, busy, done, pend, drop}, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_c2", {pulse, busy, done, pend, drop}, 8'h00);
        rst = 1'b0; trig = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_release", {pulse, busy, done, pend, drop}, 8'h00);
        @(posedge clk); #1;

        foreach (vq[i]) begin
            trig = vq[i].t;
            hi   = vq[i].h;
            lo   = vq[i].l;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {pulse, busy, done, pend, drop}, vq[i].e);
            @(posedge clk); #1;
        end
        trig = 1'b0;

        // Maximum width, with a width change while the pulse is high
        hi = 8'd255; lo = 8'd1; trig = 1'b1;
        step();
        trig = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pulse) n++;
            if (i == 50) hi = 8'd3;
            @(posedge clk); #1;
        end
        chk("h255_width", n, 255);
        chk("h255_idle", {busy, pend}, 5'h00);

        // Overflow on the PEND_W=2 instance, H=5 L=1, trig held 6 cycles
        mx = 0; np = 0; prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            trig2 = (i < 6);
            @(negedge clk);
            if (i < 6) chk($sformatf("ovf_drop%0d", i), drop2, (i >= 4) ? 1 : 0);
            if (int'(pend2) > mx) mx = int'(pend2);
            if (pulse2 && !prev) np++;
            prev = pulse2;
            @(posedge clk); #1;
        end
        trig2 = 1'b0;
        chk("ovf_pend_max", mx, 3);
        chk("ovf_pulses", np, 4);
        chk("ovf_final", {busy2, pend2}, 3'h0);

`ifdef PULSE_EMITTER_GLITCH_EN
        glitch_req = 1'b1;
        step();
        glitch_req = 1'b0;
        hi = 8'd3; lo = 8'd1; trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            gpat[5-i] = pulse;
            @(posedge clk); #1;
        end
        chk("glitch_pattern", gpat, 6'b101110);
        step();
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpat[3-i] = pulse;
            @(posedge clk); #1;
        end
        chk("glitch_clean", cpat, 4'b1110);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
